// File: rtl/sram_a_rd_seq.sv
// sram_a_rd_seq
//   Read-side sequencer for the 8-row A-operand SRAM array. A single issue
//   counter t drives every row: row r reads slot (t - r), which gives one cycle
//   of systolic skew per row. pe_valid is re delayed by one cycle, which lines
//   it up with the SRAM's registered read data.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   start      launch request, sampled only in IDLE
//   base_addr  first read address for every row (latched on accepted start)
//   len        reads per row (latched on accepted start; 0 is ignored)
//   stall      back-pressure; freezes issue and masks re while high in RUN
//   rdaddr     per-row read address
//   re         per-row read enable
//   pe_valid   per-row read-data-valid strobe to the PE array
//   busy       high from the first RUN cycle through the DRAIN cycle
//   done       one-cycle pulse in the DRAIN cycle
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start with nonzero len
// RUN   | issuing skewed reads, t advances on every non-stalled cycle
// DRAIN | single cycle, last row's read data is valid, done pulses
module sram_a_rd_seq #(
  parameter int ENTRYS = 64,
  parameter int ROWS   = 8,
  parameter int ADDR_W = $clog2(ENTRYS),
  parameter int LEN_W  = $clog2(ENTRYS) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [LEN_W-1:0]             len,
  input  logic                         stall,
  output logic [ROWS-1:0][ADDR_W-1:0]  rdaddr,
  output logic [ROWS-1:0]              re,
  output logic [ROWS-1:0]              pe_valid,
  output logic                         busy,
  output logic                         done
);

  // t reaches at most len + ROWS - 2, so LEN_W plus room for ROWS is enough.
  localparam int T_W = LEN_W + $clog2(ROWS) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [ROWS-1:0]   pe_valid_q;
  logic [ROWS-1:0]   re_c;
  logic [T_W-1:0]    t_last;
  logic [T_W-1:0]    row_off;

  // Last issue step: row ROWS-1 issues its final read at t = len + ROWS - 2.
  assign t_last = T_W'(len_q) + T_W'(ROWS - 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      t_q        <= '0;
      pe_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      t_q        <= t_d;
      pe_valid_q <= re_c;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    t_d     = t_q;
    case (state_q)
      S_IDLE: begin
        if (start && (len != '0)) begin
          base_d  = base_addr;
          len_d   = len;
          t_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall) begin
          t_d = t_q + T_W'(1);
          if (t_q == t_last) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Row r is active for t in [r, r+len). The address depends only on t and
  // the latched base, so it holds naturally while stalled.
  always_comb begin
    re_c    = '0;
    rdaddr  = '0;
    row_off = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_off   = t_q - T_W'(r);
      rdaddr[r] = base_q;
      if ((state_q == S_RUN) && (t_q >= T_W'(r))) begin
        rdaddr[r] = base_q + row_off[ADDR_W-1:0];
      end
      if ((state_q == S_RUN) && !stall && (t_q >= T_W'(r)) &&
          (t_q < (T_W'(r) + T_W'(len_q)))) begin
        re_c[r] = 1'b1;
      end
    end
  end

  assign re       = re_c;
  assign pe_valid = pe_valid_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DRAIN);

endmodule

// File: tb/tb_sram_a_rd_seq.sv
module tb_sram_a_rd_seq;

  logic            clk;
  logic            rst;
  logic            start;
  logic [5:0]      base_addr;
  logic [6:0]      len;
  logic            stall;
  logic [7:0][5:0] rdaddr;
  logic [7:0]      re;
  logic [7:0]      pe_valid;
  logic            busy;
  logic            done;

  int n_chk;
  int n_bad;

  logic [7:0]      re_h [0:99];
  logic [7:0]      pv_h [0:99];
  logic [7:0][5:0] ad_h [0:99];
  logic            bz_h [0:99];
  logic            dn_h [0:99];

  sram_a_rd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .stall     (stall),
    .rdaddr    (rdaddr),
    .re        (re),
    .pe_valid  (pe_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  // Cycle 0 is the cycle in which start is presented. A second start (st2)
  // carries different base/len so an accepted one would be visible.
  task automatic run(input int b, input int l, input int s0, input int s1,
                     input int ncyc, input int st2, input int rc);
    for (int c = 0; c < ncyc; c++) begin
      start     = (c == 0) || (c == st2);
      base_addr = (c == 0) ? 6'(b) : 6'd20;
      len       = (c == 0) ? 7'(l) : 7'd2;
      stall     = (c >= s0) && (c <= s1);
      rst       = (c == rc);
      @(negedge clk);
      re_h[c] = re;
      pv_h[c] = pe_valid;
      ad_h[c] = rdaddr;
      bz_h[c] = busy;
      dn_h[c] = done;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stall = 1'b0;
    rst   = 1'b0;
  endtask

  // kind: 0 re[row], 1 pe_valid[row], 2 busy, 3 done; expected high in [lo,hi]
  task automatic win(input string tag, input int kind, input int row,
                     input int lo, input int hi, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic v;
      case (kind)
        0:       v = re_h[c][row];
        1:       v = pv_h[c][row];
        2:       v = bz_h[c];
        default: v = dn_h[c];
      endcase
      chk($sformatf("%s c%0d", tag, c), int'(v), int'((c >= lo) && (c <= hi)));
    end
  endtask

  // Every row must read base, base+1, ... (mod 64) exactly len times, in
  // order, and pe_valid must trail re by exactly one cycle.
  task automatic check_rows(input string tag, input int b, input int l, input int ncyc);
    for (int r = 0; r < 8; r++) begin
      int n = 0;
      int abad = 0;
      int pvn = 0;
      int pvbad = 0;
      for (int c = 0; c < ncyc; c++) begin
        if (re_h[c][r]) begin
          if (int'(ad_h[c][r]) != ((b + n) % 64)) abad++;
          n++;
        end
        if (pv_h[c][r]) pvn++;
        if ((c > 0) && (pv_h[c][r] != re_h[c-1][r])) pvbad++;
      end
      chk($sformatf("%s row%0d reads", tag, r), n, l);
      chk($sformatf("%s row%0d addr errs", tag, r), abad, 0);
      chk($sformatf("%s row%0d pv count", tag, r), pvn, l);
      chk($sformatf("%s row%0d pv align errs", tag, r), pvbad, 0);
    end
  endtask

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    stall     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset re", int'(re), 0);
    chk("reset pe_valid", int'(pe_valid), 0);
    chk("reset rdaddr nonzero", int'(rdaddr != '0), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    @(posedge clk);
    #1;

    // basic
    run(0, 4, -1, -1, 16, -1, -1);
    win("basic re0", 0, 0, 1, 4, 16);
    win("basic re7", 0, 7, 8, 11, 16);
    win("basic pv7", 1, 7, 9, 12, 16);
    win("basic done", 3, 0, 12, 12, 16);
    win("basic busy", 2, 0, 1, 12, 16);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("basic row0 addr c%0d", 1 + k), int'(ad_h[1 + k][0]), k);
      chk($sformatf("basic row7 addr c%0d", 8 + k), int'(ad_h[8 + k][7]), k);
    end
    check_rows("basic", 0, 4, 16);

    // address wrap
    run(62, 4, -1, -1, 16, -1, -1);
    chk("wrap row0 c3", int'(ad_h[3][0]), 0);
    chk("wrap row3 c7", int'(ad_h[7][3]), 1);
    win("wrap done", 3, 0, 12, 12, 16);
    check_rows("wrap", 62, 4, 16);

    // stall in c3-c4
    run(0, 4, 3, 4, 18, -1, -1);
    chk("stall re c3", int'(re_h[3]), 0);
    chk("stall re c4", int'(re_h[4]), 0);
    chk("stall row0 re c5", int'(re_h[5][0]), 1);
    chk("stall row0 addr c5", int'(ad_h[5][0]), 2);
    chk("stall row0 addr held c4", int'(ad_h[4][0]), 2);
    win("stall re7", 0, 7, 10, 13, 18);
    win("stall done", 3, 0, 14, 14, 18);
    win("stall busy", 2, 0, 1, 14, 18);
    check_rows("stall", 0, 4, 18);

    // len == 0 is ignored
    run(9, 0, -1, -1, 6, -1, -1);
    for (int c = 0; c < 6; c++) chk($sformatf("len0 re c%0d", c), int'(re_h[c]), 0);
    win("len0 busy", 2, 0, 1, 0, 6);
    win("len0 done", 3, 0, 1, 0, 6);

    // second start while busy is ignored
    run(0, 4, -1, -1, 16, 5, -1);
    win("restart done", 3, 0, 12, 12, 16);
    win("restart busy", 2, 0, 1, 12, 16);
    check_rows("restart", 0, 4, 16);

    // reset mid-run at c6, new start at c7
    run(0, 8, -1, -1, 7, -1, 6);
    win("midrst busy", 2, 0, 1, 6, 7);
    run(3, 2, -1, -1, 13, -1, -1);
    chk("midrst re c7", int'(re_h[0]), 0);
    chk("midrst pv c7", int'(pv_h[0]), 0);
    chk("midrst busy c7", int'(bz_h[0]), 0);
    win("midrst new done", 3, 0, 10, 10, 13);
    win("midrst new busy", 2, 0, 1, 10, 13);
    check_rows("midrst new", 3, 2, 13);

    // full length, then back-to-back start in c73
    run(0, 64, -1, -1, 73, -1, -1);
    win("full re0", 0, 0, 1, 64, 73);
    win("full re7", 0, 7, 8, 71, 73);
    win("full done", 3, 0, 72, 72, 73);
    check_rows("full", 0, 64, 73);
    run(5, 1, -1, -1, 12, -1, -1);
    win("b2b done", 3, 0, 9, 9, 12);
    win("b2b busy", 2, 0, 1, 9, 12);
    check_rows("b2b", 5, 1, 12);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
